// File: rtl/demux_1_3_stream.sv
// Registered 1-to-3 stream demultiplexer with a one-entry valid/ready register per channel.
// Routes each word by explicit select or by a round-robin pointer; counts words sent to s=11.
module demux_1_3_stream #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [1:0]       s,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0_data,
    output logic [WIDTH-1:0] y1_data,
    output logic [WIDTH-1:0] y2_data,
    output logic             y0_valid,
    output logic             y1_valid,
    output logic             y2_valid,
    input  logic             y0_ready,
    input  logic             y1_ready,
    input  logic             y2_ready,
    output logic [1:0]       rr_ptr,
    output logic             drop,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [2:0]       valid_q;
    logic [WIDTH-1:0] data_q [3];
    logic [1:0]       rr_ptr_q;
    logic             drop_q;
    logic [CNT_W-1:0] drop_cnt_q;

    logic [1:0] tgt;
    logic [2:0] ready_vec;
    logic [2:0] acc_vec;
    logic       accept;
    logic       drop_acc;

    assign ready_vec = {y2_ready, y1_ready, y0_ready};

    always_comb begin
        tgt      = mode ? rr_ptr_q : s;
        in_ready = 1'b1;
        case (tgt)
            2'd0:    in_ready = !valid_q[0] || ready_vec[0];
            2'd1:    in_ready = !valid_q[1] || ready_vec[1];
            2'd2:    in_ready = !valid_q[2] || ready_vec[2];
            default: in_ready = 1'b1; // invalid select: word is discarded
        endcase
        accept   = in_valid && in_ready;
        acc_vec  = {accept && (tgt == 2'd2), accept && (tgt == 2'd1), accept && (tgt == 2'd0)};
        drop_acc = accept && (tgt == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            for (int k = 0; k < 3; k++) begin
                data_q[k] <= '0;
            end
            rr_ptr_q   <= 2'd0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            // An accept wins over a drain so a channel can refill in the cycle it empties.
            for (int k = 0; k < 3; k++) begin
                if (acc_vec[k]) begin
                    valid_q[k] <= 1'b1;
                    data_q[k]  <= in_data;
                end else if (valid_q[k] && ready_vec[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
            if (accept && mode) begin
                rr_ptr_q <= (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
            end
            drop_q <= drop_acc;
            if (drop_acc && (drop_cnt_q != {CNT_W{1'b1}})) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    assign y0_valid = valid_q[0];
    assign y1_valid = valid_q[1];
    assign y2_valid = valid_q[2];
    assign y0_data  = data_q[0];
    assign y1_data  = data_q[1];
    assign y2_data  = data_q[2];
    assign rr_ptr   = rr_ptr_q;
    assign drop     = drop_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_1_3_stream.sv
// Bench for demux_1_3_stream: per-channel queues of expected words, filled on drive and
// drained when a channel hands a word to its consumer.
module tb_demux_1_3_stream;

    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode;
    logic [1:0]   s;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready, in_ready2;
    logic [W-1:0] y0_data, y1_data, y2_data;
    logic         y0_valid, y1_valid, y2_valid;
    logic         y0_ready, y1_ready, y2_ready;
    logic [1:0]   rr_ptr;
    logic         drop;
    logic [7:0]   drop_cnt;
    logic [W-1:0] d2_y0_data, d2_y1_data, d2_y2_data;
    logic         d2_y0_valid, d2_y1_valid, d2_y2_valid;
    logic [1:0]   d2_rr_ptr;
    logic         d2_drop;
    logic [1:0]   d2_drop_cnt;

    logic [2:0]   yv;
    logic [W-1:0] yd [3];
    assign yv    = {y2_valid, y1_valid, y0_valid};
    assign yd[0] = y0_data;
    assign yd[1] = y1_data;
    assign yd[2] = y2_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_rr = 2'd0;
    logic [W-1:0] q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    demux_1_3_stream #(.WIDTH(W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .s(s), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .y0_data(y0_data), .y1_data(y1_data), .y2_data(y2_data),
        .y0_valid(y0_valid), .y1_valid(y1_valid), .y2_valid(y2_valid), .y0_ready(y0_ready),
        .y1_ready(y1_ready), .y2_ready(y2_ready), .rr_ptr(rr_ptr), .drop(drop),
        .drop_cnt(drop_cnt)
    );

    // Narrow-counter instance, used for the saturation check.
    demux_1_3_stream #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .s(s), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .y0_data(d2_y0_data), .y1_data(d2_y1_data),
        .y2_data(d2_y2_data), .y0_valid(d2_y0_valid), .y1_valid(d2_y1_valid),
        .y2_valid(d2_y2_valid), .y0_ready(y0_ready), .y1_ready(y1_ready), .y2_ready(y2_ready),
        .rr_ptr(d2_rr_ptr), .drop(d2_drop), .drop_cnt(d2_drop_cnt)
    );

    function automatic void sb_push(int k, logic [W-1:0] d);
        if (k == 0) q0.push_back(d);
        else if (k == 1) q1.push_back(d);
        else q2.push_back(d);
    endfunction

    function automatic logic [W-1:0] sb_pop(int k);
        if (k == 0) return (q0.size() > 0) ? q0.pop_front() : 'x;
        else if (k == 1) return (q1.size() > 0) ? q1.pop_front() : 'x;
        else return (q2.size() > 0) ? q2.pop_front() : 'x;
    endfunction

    function automatic logic [W-1:0] sb_peek(int k);
        if (k == 0) return (q0.size() > 0) ? q0[0] : 'x;
        else if (k == 1) return (q1.size() > 0) ? q1[0] : 'x;
        else return (q2.size() > 0) ? q2[0] : 'x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b0; s = 2'd0; in_valid = 1'b0; in_data = '0;
        y0_ready = 1'b1; y1_ready = 1'b1; y2_ready = 1'b1;
        #3;
        n_checks++;
        if (yv !== 3'b000 || y0_data !== '0 || y1_data !== '0 || y2_data !== '0) begin
            n_fail++;
            $display("FAIL reset_channels: got v=%b d=%0h/%0h/%0h expected v=000 d=0/0/0",
                     yv, y0_data, y1_data, y2_data);
        end
        n_checks++;
        if (rr_ptr !== 2'd0 || drop !== 1'b0 || drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rr=%0d drop=%b cnt=%0d expected 0 0 0",
                     rr_ptr, drop, drop_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_select();
        logic [W-1:0] e;
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i < 3) begin
                s = 2'(i); in_valid = 1'b1; in_data = W'(i); sb_push(i, W'(i));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 3) begin
                n_checks++;
                if (in_ready !== 1'b1 || yv[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL select_accept ch%0d: got rdy=%b v=%b expected rdy=1 v=0",
                             i, in_ready, yv[i]);
                end
            end
            if (i > 0) begin
                e = sb_pop(i - 1);
                n_checks++;
                if (yv[i-1] !== 1'b1 || yd[i-1] !== e) begin
                    n_fail++;
                    $display("FAIL select_data ch%0d: got v=%b d=%0h expected v=1 d=%0h",
                             i - 1, yv[i-1], yd[i-1], e);
                end
            end
        end
        step();
        @(negedge clk);
        n_checks++;
        if (yv !== 3'b000) begin
            n_fail++;
            $display("FAIL select_drain: got v=%b expected 000", yv);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] e;
        mode = 1'b0; s = 2'd1; y1_ready = 1'b0;
        step(); in_valid = 1'b1; in_data = 3'b101; sb_push(1, 3'b101);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_first_ready: got %b expected 1", in_ready);
        end
        step(); in_data = 3'b110;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || y1_valid !== 1'b1 || y1_data !== sb_peek(1)) begin
                n_fail++;
                $display("FAIL bp_hold cyc%0d: got rdy=%b v=%b d=%0h expected rdy=0 v=1 d=%0h",
                         c, in_ready, y1_valid, y1_data, sb_peek(1));
            end
            if (c == 0) step();
        end
        step(); y1_ready = 1'b1;
        @(negedge clk);
        e = sb_pop(1);
        n_checks++;
        if (in_ready !== 1'b1 || y1_valid !== 1'b1 || y1_data !== e) begin
            n_fail++;
            $display("FAIL bp_drain_accept: got rdy=%b v=%b d=%0h expected rdy=1 v=1 d=%0h",
                     in_ready, y1_valid, y1_data, e);
        end
        sb_push(1, 3'b110);
        step(); in_valid = 1'b0;
        @(negedge clk);
        e = sb_pop(1);
        n_checks++;
        if (y1_valid !== 1'b1 || y1_data !== e) begin
            n_fail++;
            $display("FAIL bp_second_word: got v=%b d=%0h expected v=1 d=%0h",
                     y1_valid, y1_data, e);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (y1_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_empty: got v=%b expected 0", y1_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] e;
        int last = 0;
        mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (i < 6) begin in_valid = 1'b1; in_data = W'(i); end
            else in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (rr_ptr !== exp_rr) begin
                n_fail++; $display("FAIL rr_ptr step%0d: got %0d expected %0d", i, rr_ptr, exp_rr);
            end
            if (i > 0) begin
                e = sb_pop(last);
                n_checks++;
                if (yv[last] !== 1'b1 || yd[last] !== e) begin
                    n_fail++;
                    $display("FAIL rr_data ch%0d: got v=%b d=%0h expected v=1 d=%0h",
                             last, yv[last], yd[last], e);
                end
            end
            if (i < 6) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL rr_ready step%0d: got %b expected 1", i, in_ready);
                end
                sb_push(int'(exp_rr), in_data);
                last = int'(exp_rr);
                exp_rr = (exp_rr == 2'd2) ? 2'd0 : exp_rr + 2'd1;
            end
        end
    endtask

    task automatic test_invalid_select();
        int exp_cnt;
        int exp_cnt2;
        mode = 1'b0; s = 2'd3;
        for (int i = 0; i < 7; i++) begin
            step();
            in_valid = (i < 5); in_data = W'(7 - i);
            @(negedge clk);
            exp_cnt  = (i < 5) ? i : 5;
            exp_cnt2 = (exp_cnt < 3) ? exp_cnt : 3;
            n_checks++;
            if ((i < 5 && in_ready !== 1'b1) || yv !== 3'b000) begin
                n_fail++;
                $display("FAIL drop_route step%0d: got rdy=%b v=%b expected rdy=1 v=000",
                         i, in_ready, yv);
            end
            n_checks++;
            if (drop !== (i >= 1 && i <= 5)) begin
                n_fail++;
                $display("FAIL drop_pulse step%0d: got %b expected %b", i, drop, (i >= 1 && i <= 5));
            end
            n_checks++;
            if (drop_cnt !== 8'(exp_cnt) || d2_drop_cnt !== 2'(exp_cnt2)) begin
                n_fail++;
                $display("FAIL drop_cnt step%0d: got %0d/%0d expected %0d/%0d",
                         i, drop_cnt, d2_drop_cnt, exp_cnt, exp_cnt2);
            end
        end
    endtask

    task automatic test_stalled_pointer();
        logic [W-1:0] e;
        logic [1:0]   rr_seq [5];
        logic [1:0]   tmp;
        rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd2; rr_seq[3] = 2'd0; rr_seq[4] = 2'd1;
        mode = 1'b1; y1_ready = 1'b0; y0_ready = 1'b1; y2_ready = 1'b1;
        // Words 1..4 go to ch0,ch1,ch2,ch0; word 5 stalls on the full ch1.
        for (int c = 0; c < 6; c++) begin
            step();
            if (c < 5) begin in_valid = 1'b1; in_data = W'(c + 1); end
            @(negedge clk);
            tmp = (c < 5) ? rr_seq[c] : 2'd1;
            n_checks++;
            if (rr_ptr !== tmp || in_ready !== (c < 4)) begin
                n_fail++;
                $display("FAIL stall_ctrl cyc%0d: got rr=%0d rdy=%b expected rr=%0d rdy=%b",
                         c, rr_ptr, in_ready, tmp, (c < 4));
            end
            if (c >= 1 && c <= 4 && c != 2) begin
                e = sb_pop(int'(rr_seq[c-1]));
                n_checks++;
                if (yv[rr_seq[c-1]] !== 1'b1 || yd[rr_seq[c-1]] !== e) begin
                    n_fail++;
                    $display("FAIL stall_drain cyc%0d: got v=%b d=%0h expected v=1 d=%0h",
                             c, yv[rr_seq[c-1]], yd[rr_seq[c-1]], e);
                end
            end
            if (c >= 2) begin
                n_checks++;
                if (y1_valid !== 1'b1 || y1_data !== sb_peek(1)) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc%0d: got v=%b d=%0h expected v=1 d=%0h",
                             c, y1_valid, y1_data, sb_peek(1));
                end
            end
            if (c < 4) sb_push(int'(rr_seq[c]), W'(c + 1));
        end
        n_checks++;
        if (y0_valid !== 1'b0 || y2_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_others_empty: got v0=%b v2=%b expected 0 0", y0_valid, y2_valid);
        end
        step(); mode = 1'b0; s = 2'd2;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || rr_ptr !== 2'd1) begin
            n_fail++;
            $display("FAIL stall_retarget: got rdy=%b rr=%0d expected rdy=1 rr=1", in_ready, rr_ptr);
        end
        sb_push(2, in_data);
        step(); in_valid = 1'b0;
        @(negedge clk);
        e = sb_pop(2);
        n_checks++;
        if (y2_valid !== 1'b1 || y2_data !== e || rr_ptr !== 2'd1) begin
            n_fail++;
            $display("FAIL stall_ch2: got v=%b d=%0h rr=%0d expected v=1 d=%0h rr=1",
                     y2_valid, y2_data, rr_ptr, e);
        end
        step(); y1_ready = 1'b1;
        @(negedge clk);
        e = sb_pop(1);
        n_checks++;
        if (y1_valid !== 1'b1 || y1_data !== e) begin
            n_fail++;
            $display("FAIL stall_ch1_release: got v=%b d=%0h expected v=1 d=%0h",
                     y1_valid, y1_data, e);
        end
        step();
        @(negedge clk);
        exp_rr = 2'd1;
    endtask

    task automatic test_async_reset();
        mode = 1'b1; y0_ready = 1'b0; y1_ready = 1'b1; y2_ready = 1'b0;
        // From rr=1: words land in ch1, ch2, ch0, ch1, leaving rr=2 with ch0/ch2 held.
        for (int c = 0; c < 5; c++) begin
            step();
            in_valid = (c < 4); in_data = W'(c + 1);
        end
        @(negedge clk);
        n_checks++;
        if (y0_valid !== 1'b1 || y2_valid !== 1'b1 || rr_ptr !== 2'd2 || drop_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL areset_setup: got v0=%b v2=%b rr=%0d cnt=%0d expected 1 1 2 5",
                     y0_valid, y2_valid, rr_ptr, drop_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (yv !== 3'b000 || y0_data !== '0 || y2_data !== '0) begin
            n_fail++;
            $display("FAIL areset_channels: got v=%b d0=%0h d2=%0h expected v=000 d=0",
                     yv, y0_data, y2_data);
        end
        n_checks++;
        if (rr_ptr !== 2'd0 || drop_cnt !== 8'd0 || d2_drop_cnt !== 2'd0 || drop !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_ctrl: got rr=%0d cnt=%0d/%0d drop=%b expected 0 0/0 0",
                     rr_ptr, drop_cnt, d2_drop_cnt, drop);
        end
        q0.delete(); q1.delete(); q2.delete();
        in_valid = 1'b0; y0_ready = 1'b1; y2_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(); in_valid = 1'b1; in_data = 3'b110;
        @(negedge clk);
        n_checks++;
        if (rr_ptr !== 2'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_resume: got rr=%0d rdy=%b expected rr=0 rdy=1", rr_ptr, in_ready);
        end
        step(); in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (y0_valid !== 1'b1 || y0_data !== 3'b110 || rr_ptr !== 2'd1) begin
            n_fail++;
            $display("FAIL areset_first_word: got v0=%b d0=%0h rr=%0d expected v0=1 d0=6 rr=1",
                     y0_valid, y0_data, rr_ptr);
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_backpressure();
        test_round_robin();
        test_invalid_select();
        test_stalled_pointer();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
